// File: rtl/window_pkg.sv
// Shared definitions for the window_apply stage: default widths, Q-format
// helpers for the unsigned Q1.(W-1) coefficient format and the per-beat tag
// that travels through the pipeline next to each sample.
package window_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_COEFF_WIDTH = 18;
    localparam int DEF_FRAME_LEN   = 4096;
    localparam int DEF_CHANNELS    = 1;

    // Value of 1.0 in unsigned Q1.(width-1).
    function automatic longint COEFF_ONE(input int width);
        return longint'(1) << (width - 1);
    endfunction

    // Half an output LSB once the product is shifted right by width-1.
    function automatic longint ROUND_HALF(input int width);
        return longint'(1) << (width - 2);
    endfunction

    // Sideband carried with every sample; the sample field itself is added in
    // window_apply because its width is a module parameter.
    typedef struct packed {
        logic last;
        logic bypass;
    } window_tag_t;

endpackage

// File: rtl/window_coeff_rom.sv
// Coefficient ROM for window_apply: FRAME_LEN x COEFF_WIDTH, two-cycle read
// (array read + output register), both stages held by en so the ROM stays
// aligned with the sample pipeline during stalls.
module window_coeff_rom
    import window_pkg::*;
#(
    parameter int    COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter int    FRAME_LEN   = DEF_FRAME_LEN,
    parameter string INIT_FILE   = "window.mem"
) (
    input  logic                         clk_in,
    input  logic                         en,
    input  logic [$clog2(FRAME_LEN)-1:0] addr,
    output logic [COEFF_WIDTH-1:0]       coeff
);

    xilinx_single_port_ram_read_first #(
        .RAM_WIDTH       (COEFF_WIDTH),
        .RAM_DEPTH       (FRAME_LEN),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE"),
        .INIT_FILE       (INIT_FILE)
    ) u_ram (
        .clka   (clk_in),
        .addra  (addr),
        .dina   ('0),
        .wea    (1'b0),
        .ena    (en),
        .regcea (en),
        .douta  (coeff)
    );

endmodule

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port read-first block RAM. HIGH_PERFORMANCE adds an output register
// (two-cycle read), LOW_LATENCY returns the array read directly (one cycle).
// INIT_FILE names the power-up image bound to the array by the implementation
// flow; simulation images are placed into mem directly.
module xilinx_single_port_ram_read_first
    import window_pkg::*;
#(
    parameter int    RAM_WIDTH       = DEF_COEFF_WIDTH,
    parameter int    RAM_DEPTH       = DEF_FRAME_LEN,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter string INIT_FILE       = ""
) (
    input  logic                         clka,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         wea,
    input  logic                         ena,
    input  logic                         regcea,
    output logic [RAM_WIDTH-1:0]         douta
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data;

    // Read-first port: the read returns the old contents on a write cycle.
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                mem[addra] <= dina;
            end
            ram_data <= mem[addra];
        end
    end

    if (INIT_FILE == "") begin : g_no_image
    end else begin : g_image
    end

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
        assign douta = ram_data;
    end else begin : g_high_performance
        logic [RAM_WIDTH-1:0] douta_reg;

        // Output register stage of the two-cycle read.
        always_ff @(posedge clka) begin
            if (regcea) begin
                douta_reg <= ram_data;
            end
        end

        assign douta = douta_reg;
    end

endmodule

// File: rtl/window_apply.sv
// Window-function stage: multiplies each signed sample by the ROM coefficient
// for its frame index (shared by all interleaved channels), rounds half up and
// returns a DATA_WIDTH result four cycles later. Full valid/ready stall.
// Optional feature macro: WINDOW_BYPASS_EN adds bypass_in, which forces the
// coefficient of that beat to 1.0 so the sample passes unchanged.
module window_apply
    import window_pkg::*;
#(
    parameter int    DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int    COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter int    FRAME_LEN   = DEF_FRAME_LEN,
    parameter int    CHANNELS    = DEF_CHANNELS,
    parameter string INIT_FILE   = "window.mem"
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic                         sample_valid_in,
    output logic                         sample_ready_out,
    input  logic                         frame_start_in,
    output logic signed [DATA_WIDTH-1:0] sample_out,
    output logic                         sample_valid_out,
    input  logic                         sample_ready_in,
    output logic                         frame_last_out
`ifdef WINDOW_BYPASS_EN
    ,
    input  logic                         bypass_in
`endif
);

    localparam int IDX_W  = $clog2(FRAME_LEN);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH + 1;

    localparam logic [IDX_W-1:0]        IDX_LAST    = IDX_W'(FRAME_LEN - 1);
    localparam logic [CH_W-1:0]         CH_LAST     = CH_W'(CHANNELS - 1);
    localparam logic [COEFF_WIDTH-1:0]  COEFF_UNITY = COEFF_WIDTH'(COEFF_ONE(COEFF_WIDTH));
    localparam logic signed [PROD_W-1:0] ROUND_K    = PROD_W'(ROUND_HALF(COEFF_WIDTH));

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] sample;
        window_tag_t                  tag;
    } window_beat_t;

    logic             advance;
    logic             accept;
    logic [CH_W-1:0]  chan_cnt;
    logic [IDX_W-1:0] idx_cnt;
    logic [CH_W-1:0]  chan_cur;
    logic [IDX_W-1:0] idx_cur;
    logic             bypass_cur;

    logic             valid_s0, valid_s1, valid_s2;
    window_beat_t     beat_s0, beat_s1, beat_s2;
    logic [IDX_W-1:0] idx_s0;
    logic [COEFF_WIDTH-1:0] coeff_s2;

    logic [COEFF_WIDTH-1:0]     coeff_eff;
    logic signed [PROD_W-1:0]   sample_w;
    logic signed [PROD_W-1:0]   coeff_w;
    logic signed [PROD_W-1:0]   rounded;
    logic signed [DATA_WIDTH-1:0] result;

    // The output register is the only stage that can be blocked; every other
    // stage moves whenever it can, bubbles included.
    assign advance          = !sample_valid_out || sample_ready_in;
    assign sample_ready_out = advance;
    assign accept           = sample_valid_in && advance;

`ifdef WINDOW_BYPASS_EN
    assign bypass_cur = bypass_in;
`else
    assign bypass_cur = 1'b0;
`endif

    // Position of the current input beat; frame_start overrides the counters.
    always_comb begin
        chan_cur = frame_start_in ? '0 : chan_cnt;
        idx_cur  = frame_start_in ? '0 : idx_cnt;
    end

    // Channel counter wraps each interleave group and then steps the index.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            chan_cnt <= '0;
            idx_cnt  <= '0;
        end else if (accept) begin
            if (chan_cur == CH_LAST) begin
                chan_cnt <= '0;
                idx_cnt  <= idx_cur + IDX_W'(1);
            end else begin
                chan_cnt <= chan_cur + CH_W'(1);
                idx_cnt  <= idx_cur;
            end
        end
    end

    // Stages S0..S2 carry the beat alongside the two-cycle ROM read.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            valid_s0 <= 1'b0;
            valid_s1 <= 1'b0;
            valid_s2 <= 1'b0;
            beat_s0  <= '0;
            beat_s1  <= '0;
            beat_s2  <= '0;
            idx_s0   <= '0;
        end else if (advance) begin
            valid_s0           <= accept;
            beat_s0.sample     <= sample_in;
            beat_s0.tag.last   <= (idx_cur == IDX_LAST) && (chan_cur == CH_LAST);
            beat_s0.tag.bypass <= bypass_cur;
            idx_s0             <= idx_cur;
            valid_s1           <= valid_s0;
            beat_s1            <= beat_s0;
            valid_s2           <= valid_s1;
            beat_s2            <= beat_s1;
        end
    end

    window_coeff_rom #(
        .COEFF_WIDTH (COEFF_WIDTH),
        .FRAME_LEN   (FRAME_LEN),
        .INIT_FILE   (INIT_FILE)
    ) u_rom (
        .clk_in (clk_in),
        .en     (advance),
        .addr   (idx_s0),
        .coeff  (coeff_s2)
    );

    // Coefficients never exceed 1.0, so the truncated result cannot overflow.
    always_comb begin
        coeff_eff = beat_s2.tag.bypass ? COEFF_UNITY : coeff_s2;
        sample_w  = PROD_W'(beat_s2.sample);
        coeff_w   = signed'(PROD_W'({1'b0, coeff_eff}));
        rounded   = sample_w * coeff_w + ROUND_K;
        result    = DATA_WIDTH'(rounded >>> (COEFF_WIDTH - 1));
    end

    // S3: output register, held while downstream is not ready.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sample_valid_out <= 1'b0;
            sample_out       <= '0;
            frame_last_out   <= 1'b0;
        end else if (advance) begin
            sample_valid_out <= valid_s2;
            sample_out       <= result;
            frame_last_out   <= valid_s2 && beat_s2.tag.last;
        end
    end

endmodule

// File: tb/tb_window_apply.sv
// Directed bench for window_apply. dut_a: CHANNELS=1, dut_b: CHANNELS=2, both
// FRAME_LEN=8, 16-bit data, 18-bit coefficients (1.0 = 131072). sel routes the
// shared stimulus to one DUT and its outputs to the scoreboard.
module tb_window_apply;

    localparam int DW  = 16;
    localparam int CW  = 18;
    localparam int FL  = 8;
    localparam int ONE = 131072;

    typedef struct {
        int val;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n    = 1'b0;
    logic signed [DW-1:0] s_sample = '0;
    logic                 s_valid  = 1'b0;
    logic                 s_start  = 1'b0;
    logic                 byp      = 1'b0;
    logic                 d_ready  = 1'b1;
    bit                   sel      = 1'b0;
    bit                   rand_ready = 1'b0;

    logic                 rdy_a, rdy_b, vo_a, vo_b, last_a, last_b;
    logic signed [DW-1:0] out_a, out_b;
    logic                 ready_out, valid_out, last_out;
    logic signed [DW-1:0] out_m;

    assign ready_out = sel ? rdy_b  : rdy_a;
    assign valid_out = sel ? vo_b   : vo_a;
    assign last_out  = sel ? last_b : last_a;
    assign out_m     = sel ? out_b  : out_a;

    window_apply #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .FRAME_LEN(FL), .CHANNELS(1),
                   .INIT_FILE("window.mem")) dut_a (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .sample_in        (s_sample),
        .sample_valid_in  (s_valid && !sel),
        .sample_ready_out (rdy_a),
        .frame_start_in   (s_start),
        .sample_out       (out_a),
        .sample_valid_out (vo_a),
        .sample_ready_in  (d_ready),
        .frame_last_out   (last_a)
`ifdef WINDOW_BYPASS_EN
        ,
        .bypass_in        (byp)
`endif
    );

    window_apply #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .FRAME_LEN(FL), .CHANNELS(2),
                   .INIT_FILE("window.mem")) dut_b (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .sample_in        (s_sample),
        .sample_valid_in  (s_valid && sel),
        .sample_ready_out (rdy_b),
        .frame_start_in   (s_start),
        .sample_out       (out_b),
        .sample_valid_out (vo_b),
        .sample_ready_in  (d_ready),
        .frame_last_out   (last_b)
`ifdef WINDOW_BYPASS_EN
        ,
        .bypass_in        (byp)
`endif
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   first_out_cyc = -1;
    exp_t exp_q[$];
    exp_t e_mon;
    bit   hold_prev = 1'b0;
    int   hold_val;
    int   hold_last;

    task automatic check_eq(input string tag, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        d_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check_eq("hold_valid", int'(valid_out), 1);
                check_eq("hold_sample", int'(out_m), hold_val);
                check_eq("hold_last", int'(last_out), hold_last);
            end
            hold_prev = valid_out && !d_ready;
            hold_val  = int'(out_m);
            hold_last = int'(last_out);
            if (valid_out && d_ready) begin
                if (first_out_cyc < 0) first_out_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", int'(valid_out), 0);
                end else begin
                    e_mon = exp_q.pop_front();
                    check_eq("sample", int'(out_m), e_mon.val);
                    check_eq("last", int'(last_out), int'(e_mon.last));
                end
            end
        end
    end

    task automatic load_coeff(input bit to_b, input int k, input int v);
        assert (v >= 0 && v <= ONE) else $error("coefficient %0d exceeds 1.0", v);
        if (to_b) dut_b.u_rom.u_ram.mem[k] <= CW'(v);
        else      dut_a.u_rom.u_ram.mem[k] <= CW'(v);
    endtask

    task automatic send(input int smp, input bit st, input bit bp, input int ev, input bit el);
        exp_t e;
        bit   got;
        e.val  = ev;
        e.last = el;
        exp_q.push_back(e);
        s_sample = smp[DW-1:0];
        s_start  = st;
        byp      = bp;
        s_valid  = 1'b1;
        got      = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            got = ready_out;
        end
        if (!got) check_eq("accept_timeout", int'(ready_out), 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_start = 1'b0;
        byp     = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
        check_eq({"drain_", tag}, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat_in;
        int m;

        for (int k = 0; k < FL; k++) begin
            load_coeff(1'b0, k, k * 16384);
            load_coeff(1'b1, k, (k + 1) * 16384);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", int'(vo_a), 0);
        check_eq("rst_sample", int'(out_a), 0);
        check_eq("rst_last", int'(last_a), 0);
        check_eq("rst_ready", int'(rdy_a), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Ramp: coefficient k/8, constant 1000 -> 125*k, latency 4.
        first_out_cyc = -1;
        lat_in = cyc;
        for (int k = 0; k < FL; k++) send(1000, k == 0, 1'b0, 125 * k, k == FL - 1);
        drain("ramp");
        check_eq("latency", first_out_cyc - lat_in, 4);

        // Rounding: 0.5 on indices 0..3, 1.0 on 4..7.
        for (int k = 0; k < FL; k++) load_coeff(1'b0, k, (k < 4) ? 65536 : ONE);
        repeat (2) @(posedge clk);
        #1;
        send(3,      1'b1, 1'b0, 2,      1'b0);
        send(-3,     1'b0, 1'b0, -1,     1'b0);
        send(5,      1'b0, 1'b0, 3,      1'b0);
        send(-5,     1'b0, 1'b0, -2,     1'b0);
        send(32767,  1'b0, 1'b0, 32767,  1'b0);
        send(-32768, 1'b0, 1'b0, -32768, 1'b0);
        send(1,      1'b0, 1'b0, 1,      1'b0);
        send(-1,     1'b0, 1'b0, -1,     1'b1);
        drain("round");

        // Backpressure over three frames, coefficient (k+1)/8, sample 8*m.
        for (int k = 0; k < FL; k++) load_coeff(1'b0, k, (k + 1) * 16384);
        repeat (2) @(posedge clk);
        #1;
        rand_ready = 1'b1;
        for (int j = 0; j < 3 * FL; j++) begin
            m = j * 13 - 150;
            send(8 * m, j == 0, 1'b0, m * ((j % FL) + 1), (j % FL) == FL - 1);
        end
        drain("stall");
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with three beats in flight; first beat after uses index 0.
        send(800, 1'b1, 1'b0, 100, 1'b0);
        send(800, 1'b0, 1'b0, 200, 1'b0);
        send(800, 1'b0, 1'b0, 300, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_valid", int'(vo_a), 0);
        check_eq("midrst_sample", int'(out_a), 0);
        check_eq("midrst_last", int'(last_a), 0);
        check_eq("midrst_ready", int'(rdy_a), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(800, 1'b0, 1'b0, 100, 1'b0);
        send(800, 1'b0, 1'b0, 200, 1'b0);
        drain("post_rst");

        // Two channels: pairs share a coefficient; resync at index 5.
        sel = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < FL; k++) begin
            send(800,   k == 0, 1'b0, 100 * (k + 1),  1'b0);
            send(-1600, 1'b0,   1'b0, -200 * (k + 1), k == FL - 1);
        end
        for (int k = 0; k < 5; k++) begin
            send(800,   k == 0, 1'b0, 100 * (k + 1),  1'b0);
            send(-1600, 1'b0,   1'b0, -200 * (k + 1), 1'b0);
        end
        for (int k = 0; k < FL; k++) begin
            send(800,   k == 0, 1'b0, 100 * (k + 1),  1'b0);
            send(-1600, 1'b0,   1'b0, -200 * (k + 1), k == FL - 1);
        end
        send(800,   1'b0, 1'b0, 100,  1'b0);
        send(-1600, 1'b0, 1'b0, -200, 1'b0);
        send(800,   1'b0, 1'b0, 200,  1'b0);
        send(400,   1'b1, 1'b0, 50,   1'b0);
        send(-400,  1'b0, 1'b0, -50,  1'b0);
        drain("stereo");
        sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;

`ifdef WINDOW_BYPASS_EN
        // Hann ROM, bypass on even indices.
        load_coeff(1'b0, 0, 0);
        load_coeff(1'b0, 1, 19195);
        load_coeff(1'b0, 2, 65536);
        load_coeff(1'b0, 3, 111877);
        load_coeff(1'b0, 4, ONE);
        load_coeff(1'b0, 5, 111877);
        load_coeff(1'b0, 6, 65536);
        load_coeff(1'b0, 7, 19195);
        repeat (2) @(posedge clk);
        #1;
        first_out_cyc = -1;
        lat_in = cyc;
        send(-12345, 1'b1, 1'b1, -12345, 1'b0);
        send(1000,   1'b0, 1'b0, 146,    1'b0);
        send(32767,  1'b0, 1'b1, 32767,  1'b0);
        send(1000,   1'b0, 1'b0, 854,    1'b0);
        send(-32768, 1'b0, 1'b1, -32768, 1'b0);
        send(1000,   1'b0, 1'b0, 854,    1'b0);
        send(777,    1'b0, 1'b1, 777,    1'b0);
        send(1000,   1'b0, 1'b0, 146,    1'b1);
        drain("bypass");
        check_eq("bypass_latency", first_out_cyc - lat_in, 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
